autoconfig_chain: RTL and testbench
===================================

AUTOCONFIG_CHAIN -- requirements
Module: autoconfig_chain

Interface
REQ-001 NUM_BOARDS, 3, number of Zorro II boards presented in sequence (1..8).
REQ-002 MFG_ID, 16'h07DB, manufacturer ID shared by all boards.
REQ-003 PROD_IDS, {8'd72,8'd73,8'd74}, packed 8-bit product ID per board; board 0 in LSBs.
REQ-004 SIZE_CODES, {3'b001,3'b001,3'b000}, packed 3-bit Zorro II size code per board (000=8MB, 001=64KB ... 111=4MB).
REQ-005 MEM_MASK, 3'b001, bit set = memory board (type nibble 1110, "add to free pool" bit set); clear = IO (1100).
REQ-006 ROM_MASK, 3'b000, bit set = board has autoboot ROM: ROM-vector bit set, rom_offset 16'h0008.
REQ-007 SERIAL, 32'd1, serial number shared by all boards.
REQ-008 WAIT_PRED, 1, 1 = chain stays silent until a predecessor board is configured.
REQ-009 CLK  in  1  system clock; sole clock; all state updates on its rising edge.
REQ-010 RESET_n  in  1  synchronous, active-low reset, sampled on the CLK rising edge.
REQ-011 ADDR  in  23  CPU address A23..A1.
REQ-012 AS_n  in  1  address strobe, active low.
REQ-013 RW  in  1  1 = read.
REQ-014 DIN  in  4  data nibble D15..D12 on writes.
REQ-015 z2_state  in  2  bus-cycle phase from the Zorro II cycle tracker.
REQ-016 board_en  in  NUM_BOARDS  per-board enable; disabled boards are skipped.
REQ-017 DOUT  out  4  read-data nibble.
REQ-018 dtack  out  1  one-cycle acknowledge of an autoconfig access.
REQ-019 autoconfig_cycle  out  1  access to 0xE8xxxx while chain is active.
REQ-020 cfgout  out  1  chain finished (all boards configured, shut up or skipped).
REQ-021 configured  out  NUM_BOARDS  board has a committed base.
REQ-022 board_hit  out  NUM_BOARDS  current ADDR lies inside that board's assigned window.

Function
REQ-023 Pointer cur (0..NUM_BOARDS): index of the board being presented; NUM_BOARDS = done.
REQ-024 At reset, and after each advance, cur moves to the lowest-indexed enabled board above the previous one, or to done if none remains; the skip completes in one CLK.
REQ-025 pred_cfg sets on a write with ADDR[23:16]=E8, ADDR[8:1]=24, AS_n low; it is forced to 1 when WAIT_PRED=0.
REQ-026 AS_n is registered in the CLK domain; on its low-to-high transition, cfgin <= pred_cfg and cfgout <= (cur==done).
REQ-027 autoconfig_cycle = (ADDR[23:16]==E8) && cfgin && !cfgout.
REQ-028 In the cycle when z2_state==Z2_DATA, autoconfig_cycle=1 and dtack=0: set dtack=1 for exactly one CLK, then hold dtack at 0 until that condition recurs.
REQ-029 Reads on that cycle load DOUT from the register map for board cur. Offsets 00 and 20/21 are non-inverted; all others are inverted. Unmapped offsets return F.
REQ-030 Register map (ADDR[8:1]): 00 type/ROM; 01 size code; 02/03 product ID; 04 bit3 = MEM_MASK[cur]; 08-0B MFG_ID; 0C-13 SERIAL; 14-17 ROM offset.
REQ-031 Write to 25: latch DIN as base_lo for board cur; no advance.
REQ-032 Write to 24: base[cur] <= {DIN, base_lo}; set configured[cur]; advance cur.
REQ-033 Write to 26 (shut up): advance cur; configured[cur] stays 0.
REQ-034 Writes to other offsets are acknowledged and ignored. Writes when cur==done produce no dtack, because autoconfig_cycle is 0.
REQ-035 board_hit[i] = configured[i] && ADDR[23:16] lies in [base[i], base[i]+window-1]. window = size in 64KB units; 8MB = 128 units. The upper bound saturates at FF without wrapping.
REQ-036 Base arithmetic uses 9-bit compare so a window ending at FF does not alias to 00.
REQ-037 A write to 24 with no preceding write to 25 uses base_lo=0.

Reset
REQ-038 On RESET_n low at a CLK edge, the following clear: DOUT=0, dtack=0, cfgin=0, cfgout=0, pred_cfg=WAIT_PRED?0:1, configured=0, all bases=0, base_lo=0. cur is set to the first enabled board.
REQ-039 Reset asserted mid-access aborts the access; no partial configuration survives.

Structure
REQ-040 autoconfig_pkg holds Z2 state encodings (Z2_DATA etc.), register offset constants (24/25/26, map offsets), and the size-code-to-window function.
REQ-041 Sub-module ac_nibble_rom is combinational. It takes board parameters and an offset and returns the raw (pre-inversion) nibble. It is instantiated once and muxed by cur.

Verification
REQ-042 Scenario: defaults, pred write E80048, then read 00 for board 0. Required: DOUT=E, dtack high for 1 CLK.
REQ-043 Scenario: board 0 write 4A←3, then 48←2. Required: configured=001, base0=23; ADDR=230000 gives board_hit[0]=1, ADDR=240000 gives 0.
REQ-044 Scenario: board_en=101. Required: after board 0 is configured, read 02 returns ~prod_id[2][7:4].
REQ-045 Scenario: shut up (write 4C) on every board. Required: cfgout=1 after the next AS_n rise, configured=000, no further dtack at E8.
REQ-046 Scenario: 8MB board based at 20. Required: hit at 9F0000, no hit at A00000; 4MB board at E0 gives hit at FF0000 with no wrap to 00.
REQ-047 Scenario: RESET_n low during Z2_DATA after writing 4A. Required: all outputs at reset values; a subsequent write to 48 yields base_lo=0.

Source files
------------

// File: rtl/autoconfig_pkg.sv
// Shared definitions for the Zorro II autoconfig chain.
//   - Z2 bus-cycle phase encodings produced by the external cycle tracker
//   - autoconfig register offsets (ADDR[8:1] word offsets inside 0xE8xxxx)
//   - size_window(): Zorro II size code -> window length in 64KB units
package autoconfig_pkg;

    typedef enum logic [1:0] {
        Z2_IDLE = 2'd0,
        Z2_ADDR = 2'd1,
        Z2_DATA = 2'd2,
        Z2_END  = 2'd3
    } z2_state_t;

    // Upper address byte of the autoconfig space.
    localparam logic [7:0] AC_SPACE = 8'hE8;

    // Read map (word offsets).
    localparam logic [7:0] OFF_TYPE    = 8'h00;
    localparam logic [7:0] OFF_SIZE    = 8'h01;
    localparam logic [7:0] OFF_PROD_HI = 8'h02;
    localparam logic [7:0] OFF_PROD_LO = 8'h03;
    localparam logic [7:0] OFF_FLAGS   = 8'h04;
    localparam logic [7:0] OFF_MFG     = 8'h08;  // 08..0B, high nibble first
    localparam logic [7:0] OFF_SERIAL  = 8'h0C;  // 0C..13, high nibble first
    localparam logic [7:0] OFF_ROM_VEC = 8'h14;  // 14..17, high nibble first
    localparam logic [7:0] OFF_INT0    = 8'h20;
    localparam logic [7:0] OFF_INT1    = 8'h21;

    // Write map (word offsets).
    localparam logic [7:0] OFF_BASE_HI = 8'h24;
    localparam logic [7:0] OFF_BASE_LO = 8'h25;
    localparam logic [7:0] OFF_SHUTUP  = 8'h26;

    // Boot ROM vector reported by boards that carry an autoboot ROM.
    localparam logic [15:0] ROM_VECTOR = 16'h0008;

    // Window length in 64KB units. Code 000 is the 8MB case (128 units);
    // codes 001..111 double from 64KB up to 4MB.
    function automatic logic [7:0] size_window(input logic [2:0] code);
        logic [7:0] w;
        case (code)
            3'b000:  w = 8'd128;
            3'b001:  w = 8'd1;
            3'b010:  w = 8'd2;
            3'b011:  w = 8'd4;
            3'b100:  w = 8'd8;
            3'b101:  w = 8'd16;
            3'b110:  w = 8'd32;
            default: w = 8'd64;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/ac_nibble_rom.sv
// Combinational autoconfig register map for one board.
// Returns the raw (pre-inversion) nibble for a word offset; the caller
// applies the inversion rule of the autoconfig space.
//   mfg_id    : manufacturer ID
//   serial    : serial number
//   prod_id   : product ID of the selected board
//   size_code : Zorro II size code of the selected board
//   is_mem    : board is memory (add to free pool)
//   has_rom   : board carries an autoboot ROM
//   offset    : ADDR[8:1] word offset
//   nibble    : raw register nibble
module ac_nibble_rom
    import autoconfig_pkg::*;
(
    input  logic [15:0] mfg_id,
    input  logic [31:0] serial,
    input  logic [7:0]  prod_id,
    input  logic [2:0]  size_code,
    input  logic        is_mem,
    input  logic        has_rom,
    input  logic [7:0]  offset,
    output logic [3:0]  nibble
);

    logic [15:0] rom_off;

    assign rom_off = has_rom ? ROM_VECTOR : 16'h0000;

    always_comb begin
        nibble = 4'h0;
        case (offset)
            // Zorro II type: bits 11, then memory/free-pool, then ROM vector valid.
            OFF_TYPE:           nibble = {2'b11, is_mem, has_rom};
            OFF_SIZE:           nibble = {1'b0, size_code};
            OFF_PROD_HI:        nibble = prod_id[7:4];
            OFF_PROD_LO:        nibble = prod_id[3:0];
            OFF_FLAGS:          nibble = {is_mem, 3'b000};
            OFF_MFG:            nibble = mfg_id[15:12];
            OFF_MFG + 8'd1:     nibble = mfg_id[11:8];
            OFF_MFG + 8'd2:     nibble = mfg_id[7:4];
            OFF_MFG + 8'd3:     nibble = mfg_id[3:0];
            OFF_SERIAL:         nibble = serial[31:28];
            OFF_SERIAL + 8'd1:  nibble = serial[27:24];
            OFF_SERIAL + 8'd2:  nibble = serial[23:20];
            OFF_SERIAL + 8'd3:  nibble = serial[19:16];
            OFF_SERIAL + 8'd4:  nibble = serial[15:12];
            OFF_SERIAL + 8'd5:  nibble = serial[11:8];
            OFF_SERIAL + 8'd6:  nibble = serial[7:4];
            OFF_SERIAL + 8'd7:  nibble = serial[3:0];
            OFF_ROM_VEC:        nibble = rom_off[15:12];
            OFF_ROM_VEC + 8'd1: nibble = rom_off[11:8];
            OFF_ROM_VEC + 8'd2: nibble = rom_off[7:4];
            OFF_ROM_VEC + 8'd3: nibble = rom_off[3:0];
            // These two are read without inversion; all ones matches the
            // appearance of unmapped space.
            OFF_INT0, OFF_INT1: nibble = 4'hF;
            // Unmapped offsets are inverted by the caller, so 0 reads as F.
            default:            nibble = 4'h0;
        endcase
    end

endmodule

// File: rtl/autoconfig_chain.sv
// Zorro II autoconfig chain: presents NUM_BOARDS boards one after another in
// the 0xE8xxxx space, accepts their base addresses, and reports which
// configured window the current address falls in.
//   CLK, RESET_n      : clock, synchronous active-low reset
//   ADDR[23:1]        : CPU address
//   AS_n, RW, DIN     : address strobe (low), 1=read, write data D15..D12
//   z2_state          : bus phase from the Zorro II cycle tracker
//   board_en          : per-board enable; disabled boards are skipped
//   DOUT              : read-data nibble
//   dtack             : acknowledge of an autoconfig access
//   autoconfig_cycle  : access to the autoconfig space while the chain is active
//   cfgout            : chain finished
//   configured        : per-board committed base
//   board_hit         : ADDR inside a configured board's window
//
// Handshake: an access is taken in the CLK cycle where z2_state is Z2_DATA,
// autoconfig_cycle is 1 and dtack is 0. dtack is then 1 for exactly that one
// following CLK and returns to 0; DOUT is valid from the same edge that
// raises dtack and holds until the next read access or reset.
module autoconfig_chain
    import autoconfig_pkg::*;
#(
    parameter int                        NUM_BOARDS = 3,
    parameter logic [15:0]               MFG_ID     = 16'h07DB,
    parameter logic [8*NUM_BOARDS-1:0]   PROD_IDS   = {8'd72, 8'd73, 8'd74},
    parameter logic [3*NUM_BOARDS-1:0]   SIZE_CODES = {3'b001, 3'b001, 3'b000},
    parameter logic [NUM_BOARDS-1:0]     MEM_MASK   = 3'b001,
    parameter logic [NUM_BOARDS-1:0]     ROM_MASK   = 3'b000,
    parameter logic [31:0]               SERIAL     = 32'd1,
    parameter int                        WAIT_PRED  = 1
)
(
    input  logic                  CLK,
    input  logic                  RESET_n,
    input  logic [23:1]           ADDR,
    input  logic                  AS_n,
    input  logic                  RW,
    input  logic [3:0]            DIN,
    input  logic [1:0]            z2_state,
    input  logic [NUM_BOARDS-1:0] board_en,
    output logic [3:0]            DOUT,
    output logic                  dtack,
    output logic                  autoconfig_cycle,
    output logic                  cfgout,
    output logic [NUM_BOARDS-1:0] configured,
    output logic [NUM_BOARDS-1:0] board_hit
);

    localparam int            CW       = $clog2(NUM_BOARDS + 1);
    localparam logic [CW-1:0] CUR_DONE = CW'(NUM_BOARDS);

    logic [CW-1:0] cur;
    logic [CW-1:0] cur_first;
    logic [CW-1:0] cur_next;
    logic          as_q;
    logic          cfgin;
    logic          pred_cfg;
    logic [3:0]    base_lo;
    logic [7:0]    base [NUM_BOARDS];

    logic [7:0]    off;
    logic          in_space;
    logic          access;
    logic          as_rise;

    logic [7:0]    sel_prod;
    logic [2:0]    sel_size;
    logic          sel_mem;
    logic          sel_rom;
    logic [3:0]    raw_nibble;
    logic [3:0]    rd_nibble;

    logic [8:0]    addr9;
    logic [8:0]    lo9;
    logic [8:0]    hi9;

    logic          unused_addr;

    assign off              = ADDR[8:1];
    assign in_space         = (ADDR[23:16] == AC_SPACE);
    assign autoconfig_cycle = in_space && cfgin && !cfgout;
    assign access           = (z2_state == Z2_DATA) && autoconfig_cycle && !dtack;
    assign as_rise          = !as_q && AS_n;
    assign unused_addr      = &{1'b0, ADDR[15:9]};

    // Lowest enabled board overall (reset) and lowest enabled above cur (advance).
    always_comb begin
        cur_first = CUR_DONE;
        cur_next  = CUR_DONE;
        for (int i = NUM_BOARDS - 1; i >= 0; i--) begin
            if (board_en[i]) begin
                cur_first = CW'(i);
            end
            if (board_en[i] && (CW'(i) > cur)) begin
                cur_next = CW'(i);
            end
        end
    end

    // Parameters of the board currently being presented.
    always_comb begin
        sel_prod = PROD_IDS[7:0];
        sel_size = SIZE_CODES[2:0];
        sel_mem  = MEM_MASK[0];
        sel_rom  = ROM_MASK[0];
        for (int i = 0; i < NUM_BOARDS; i++) begin
            if (cur == CW'(i)) begin
                sel_prod = PROD_IDS[i*8 +: 8];
                sel_size = SIZE_CODES[i*3 +: 3];
                sel_mem  = MEM_MASK[i];
                sel_rom  = ROM_MASK[i];
            end
        end
    end

    ac_nibble_rom u_rom (
        .mfg_id    (MFG_ID),
        .serial    (SERIAL),
        .prod_id   (sel_prod),
        .size_code (sel_size),
        .is_mem    (sel_mem),
        .has_rom   (sel_rom),
        .offset    (off),
        .nibble    (raw_nibble)
    );

    // Only the type nibble and the two interrupt offsets are stored true.
    assign rd_nibble = ((off == OFF_TYPE) || (off == OFF_INT0) || (off == OFF_INT1))
                       ? raw_nibble : ~raw_nibble;

    // Window compare in 9 bits: a window that runs past FF simply caps the
    // upper bound above any reachable address instead of wrapping to 00.
    always_comb begin
        board_hit = '0;
        addr9     = {1'b0, ADDR[23:16]};
        lo9       = '0;
        hi9       = '0;
        for (int i = 0; i < NUM_BOARDS; i++) begin
            lo9 = {1'b0, base[i]};
            hi9 = lo9 + {1'b0, size_window(SIZE_CODES[i*3 +: 3])} - 9'd1;
            if (configured[i] && (addr9 >= lo9) && (addr9 <= hi9)) begin
                board_hit[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            // as_q resets high so leaving reset with AS_n idle is not a rise.
            as_q       <= 1'b1;
            DOUT       <= 4'h0;
            dtack      <= 1'b0;
            cfgin      <= 1'b0;
            cfgout     <= 1'b0;
            pred_cfg   <= (WAIT_PRED == 0);
            configured <= '0;
            base_lo    <= 4'h0;
            cur        <= cur_first;
            for (int i = 0; i < NUM_BOARDS; i++) begin
                base[i] <= 8'h00;
            end
        end else begin
            as_q  <= AS_n;
            dtack <= access;

            if (as_rise) begin
                cfgin  <= pred_cfg;
                cfgout <= (cur == CUR_DONE);
            end

            // Snoop the predecessor's base write; sticky until reset.
            if (WAIT_PRED == 0) begin
                pred_cfg <= 1'b1;
            end else if (in_space && !AS_n && !RW && (off == OFF_BASE_HI)) begin
                pred_cfg <= 1'b1;
            end

            if (access) begin
                if (RW) begin
                    DOUT <= rd_nibble;
                end else begin
                    case (off)
                        OFF_BASE_LO: base_lo <= DIN;
                        OFF_BASE_HI: begin
                            for (int i = 0; i < NUM_BOARDS; i++) begin
                                if (cur == CW'(i)) begin
                                    base[i]       <= {DIN, base_lo};
                                    configured[i] <= 1'b1;
                                end
                            end
                            // Each board starts with a fresh low nibble.
                            base_lo <= 4'h0;
                            cur     <= cur_next;
                        end
                        OFF_SHUTUP: begin
                            base_lo <= 4'h0;
                            cur     <= cur_next;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_autoconfig_chain.sv
// Directed bench for autoconfig_chain. Board set used here:
//   board 0: 64KB memory, product 74 (0x4A), no ROM
//   board 1: 8MB IO, product 73 (0x49), autoboot ROM
//   board 2: 4MB IO, product 72 (0x48), no ROM
module tb_autoconfig_chain;
    import autoconfig_pkg::*;

    localparam int   NB = 3;
    localparam logic R  = 1'b1;
    localparam logic W  = 1'b0;

    logic          CLK = 1'b0;
    logic          RESET_n;
    logic [23:1]   ADDR;
    logic          AS_n;
    logic          RW;
    logic [3:0]    DIN;
    logic [1:0]    z2_state;
    logic [NB-1:0] board_en;
    logic [3:0]    DOUT;
    logic          dtack;
    logic          autoconfig_cycle;
    logic          cfgout;
    logic [NB-1:0] configured;
    logic [NB-1:0] board_hit;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [23:0] a;
        logic        rw;
        logic [3:0]  din;
        logic        ack;
        logic [3:0]  dout;
        logic [2:0]  cfg;
        logic        done;
    } vec_t;

    typedef struct {
        logic [23:0] a;
        logic [2:0]  hit;
    } hit_t;

    vec_t tbl[$];
    hit_t hits[$];

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    autoconfig_chain #(
        .NUM_BOARDS (NB),
        .SIZE_CODES ({3'b111, 3'b000, 3'b001}),
        .ROM_MASK   (3'b010)
    ) dut (
        .CLK              (CLK),
        .RESET_n          (RESET_n),
        .ADDR             (ADDR),
        .AS_n             (AS_n),
        .RW               (RW),
        .DIN              (DIN),
        .z2_state         (z2_state),
        .board_en         (board_en),
        .DOUT             (DOUT),
        .dtack            (dtack),
        .autoconfig_cycle (autoconfig_cycle),
        .cfgout           (cfgout),
        .configured       (configured),
        .board_hit        (board_hit)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [23:0] a, input logic rw, input logic [3:0] din,
                                input logic ack, input logic [3:0] dout,
                                input logic [2:0] cfg, input logic done);
        vec_t v;
        v.a = a; v.rw = rw; v.din = din; v.ack = ack; v.dout = dout; v.cfg = cfg; v.done = done;
        return v;
    endfunction

    function automatic hit_t mh(input logic [23:0] a, input logic [2:0] hit);
        hit_t h;
        h.a = a; h.hit = hit;
        return h;
    endfunction

    task automatic do_reset(input logic [NB-1:0] en);
        @(negedge CLK);
        RESET_n = 1'b0; board_en = en; AS_n = 1'b1; RW = 1'b1;
        z2_state = Z2_IDLE; ADDR = '0; DIN = 4'h0;
        repeat (2) @(negedge CLK);
        RESET_n = 1'b1;
        @(negedge CLK);
    endtask

    // One full bus cycle: address, data, end, strobe release.
    task automatic bus(input logic [23:0] a, input logic rw, input logic [3:0] din,
                       output logic ac, output logic ack, output logic ack2, output logic [3:0] dout);
        @(negedge CLK);
        ADDR = a[23:1]; RW = rw; DIN = din; AS_n = 1'b0; z2_state = Z2_ADDR;
        @(negedge CLK);
        z2_state = Z2_DATA;
        #1 ac = autoconfig_cycle;
        @(negedge CLK);
        ack = dtack; dout = DOUT; z2_state = Z2_END;
        @(negedge CLK);
        ack2 = dtack; AS_n = 1'b1; z2_state = Z2_IDLE;
        @(negedge CLK);
    endtask

    task automatic run_vec(input string tag, input int idx, input vec_t v);
        logic       ac, ack, ack2;
        logic [3:0] dout;
        bus(v.a, v.rw, v.din, ac, ack, ack2, dout);
        check($sformatf("%s[%0d] autoconfig_cycle", tag, idx), 32'(ac), 32'(v.ack));
        check($sformatf("%s[%0d] dtack", tag, idx), 32'(ack), 32'(v.ack));
        check($sformatf("%s[%0d] dtack_single", tag, idx), 32'(ack2), 32'(1'b0));
        if (v.rw && v.ack)
            check($sformatf("%s[%0d] DOUT", tag, idx), 32'(dout), 32'(v.dout));
        check($sformatf("%s[%0d] configured", tag, idx), 32'(configured), 32'(v.cfg));
        check($sformatf("%s[%0d] cfgout", tag, idx), 32'(cfgout), 32'(v.done));
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) run_vec(tag, i, tbl[i]);
        tbl.delete();
    endtask

    task automatic run_hits(input string tag);
        for (int i = 0; i < hits.size(); i++) begin
            @(negedge CLK);
            ADDR = hits[i].a[23:1];
            #1 check($sformatf("%s[%0d] board_hit @%06h", tag, i, hits[i].a),
                     32'(board_hit), 32'(hits[i].hit));
        end
        hits.delete();
    endtask

    // ---------------- test ----------------
    initial begin
        RESET_n = 1'b0; AS_n = 1'b1; RW = 1'b1; DIN = 4'h0;
        ADDR = '0; z2_state = Z2_IDLE; board_en = '1;

        // Reset state
        do_reset(3'b111);
        check("reset DOUT", 32'(DOUT), 32'h0);
        check("reset dtack", 32'(dtack), 32'h0);
        check("reset cfgout", 32'(cfgout), 32'h0);
        check("reset configured", 32'(configured), 32'h0);
        check("reset board_hit", 32'(board_hit), 32'h0);
        @(negedge CLK); ADDR = 23'h740000;  // byte address E80000
        #1 check("reset autoconfig_cycle", 32'(autoconfig_cycle), 32'h0);

        // Full chain walk, all boards enabled
        tbl.push_back(mk(24'hE80048, W, 4'h0, 1'b0, 4'h0, 3'b000, 1'b0)); // predecessor
        tbl.push_back(mk(24'hE80000, R, 4'h0, 1'b1, 4'hE, 3'b000, 1'b0)); // b0 type
        tbl.push_back(mk(24'hE80002, R, 4'h0, 1'b1, 4'hE, 3'b000, 1'b0)); // b0 size 001
        tbl.push_back(mk(24'hE80004, R, 4'h0, 1'b1, 4'hB, 3'b000, 1'b0)); // prod hi ~4
        tbl.push_back(mk(24'hE80006, R, 4'h0, 1'b1, 4'h5, 3'b000, 1'b0)); // prod lo ~A
        tbl.push_back(mk(24'hE80008, R, 4'h0, 1'b1, 4'h7, 3'b000, 1'b0)); // flags ~8
        tbl.push_back(mk(24'hE80010, R, 4'h0, 1'b1, 4'hF, 3'b000, 1'b0)); // mfg ~0
        tbl.push_back(mk(24'hE80012, R, 4'h0, 1'b1, 4'h8, 3'b000, 1'b0)); // mfg ~7
        tbl.push_back(mk(24'hE80014, R, 4'h0, 1'b1, 4'h2, 3'b000, 1'b0)); // mfg ~D
        tbl.push_back(mk(24'hE80016, R, 4'h0, 1'b1, 4'h4, 3'b000, 1'b0)); // mfg ~B
        tbl.push_back(mk(24'hE80018, R, 4'h0, 1'b1, 4'hF, 3'b000, 1'b0)); // serial top
        tbl.push_back(mk(24'hE80026, R, 4'h0, 1'b1, 4'hE, 3'b000, 1'b0)); // serial ~1
        tbl.push_back(mk(24'hE80030, R, 4'h0, 1'b1, 4'hF, 3'b000, 1'b0)); // unmapped
        tbl.push_back(mk(24'hE8004A, W, 4'h3, 1'b1, 4'h0, 3'b000, 1'b0)); // b0 base_lo
        tbl.push_back(mk(24'hE80048, W, 4'h2, 1'b1, 4'h0, 3'b001, 1'b0)); // b0 base 23
        tbl.push_back(mk(24'hE80000, R, 4'h0, 1'b1, 4'hD, 3'b001, 1'b0)); // b1 IO+ROM
        tbl.push_back(mk(24'hE80002, R, 4'h0, 1'b1, 4'hF, 3'b001, 1'b0)); // b1 8MB
        tbl.push_back(mk(24'hE8002C, R, 4'h0, 1'b1, 4'hF, 3'b001, 1'b0)); // rom vec ~0
        tbl.push_back(mk(24'hE8002E, R, 4'h0, 1'b1, 4'h7, 3'b001, 1'b0)); // rom vec ~8
        tbl.push_back(mk(24'hE80006, R, 4'h0, 1'b1, 4'h6, 3'b001, 1'b0)); // prod lo ~9
        tbl.push_back(mk(24'hE80090, W, 4'h5, 1'b1, 4'h0, 3'b001, 1'b0)); // ignored write
        tbl.push_back(mk(24'hE8004A, W, 4'h0, 1'b1, 4'h0, 3'b001, 1'b0));
        tbl.push_back(mk(24'hE80048, W, 4'h2, 1'b1, 4'h0, 3'b011, 1'b0)); // b1 base 20
        tbl.push_back(mk(24'hE80000, R, 4'h0, 1'b1, 4'hC, 3'b011, 1'b0)); // b2 IO
        tbl.push_back(mk(24'hE80002, R, 4'h0, 1'b1, 4'h8, 3'b011, 1'b0)); // b2 4MB
        tbl.push_back(mk(24'hE80004, R, 4'h0, 1'b1, 4'hB, 3'b011, 1'b0)); // prod hi ~4
        tbl.push_back(mk(24'hE8004A, W, 4'h0, 1'b1, 4'h0, 3'b011, 1'b0));
        tbl.push_back(mk(24'hE80048, W, 4'hE, 1'b1, 4'h0, 3'b111, 1'b1)); // b2 base E0
        tbl.push_back(mk(24'hE80000, R, 4'h0, 1'b0, 4'h0, 3'b111, 1'b1)); // chain done
        tbl.push_back(mk(24'hE80048, W, 4'h5, 1'b0, 4'h0, 3'b111, 1'b1));
        run_table("walk");

        hits.push_back(mh(24'h230000, 3'b011));
        hits.push_back(mh(24'h240000, 3'b010));
        hits.push_back(mh(24'h220000, 3'b010));
        hits.push_back(mh(24'h200000, 3'b010));
        hits.push_back(mh(24'h1F0000, 3'b000));
        hits.push_back(mh(24'h9F0000, 3'b010));
        hits.push_back(mh(24'hA00000, 3'b000));
        hits.push_back(mh(24'hE00000, 3'b100));
        hits.push_back(mh(24'hDF0000, 3'b000));
        hits.push_back(mh(24'hFF0000, 3'b100));
        hits.push_back(mh(24'h000000, 3'b000));
        run_hits("walk_hit");

        // Board 1 disabled: after board 0 the chain jumps to board 2
        do_reset(3'b101);
        tbl.push_back(mk(24'hE80000, R, 4'h0, 1'b0, 4'h0, 3'b000, 1'b0)); // silent before pred
        tbl.push_back(mk(24'hE80048, W, 4'h0, 1'b0, 4'h0, 3'b000, 1'b0));
        tbl.push_back(mk(24'hE8004A, W, 4'h3, 1'b1, 4'h0, 3'b000, 1'b0));
        tbl.push_back(mk(24'hE80048, W, 4'h2, 1'b1, 4'h0, 3'b001, 1'b0));
        tbl.push_back(mk(24'hE80004, R, 4'h0, 1'b1, 4'hB, 3'b001, 1'b0)); // ~0x48[7:4]
        tbl.push_back(mk(24'hE80006, R, 4'h0, 1'b1, 4'h7, 3'b001, 1'b0)); // ~0x48[3:0]
        tbl.push_back(mk(24'hE80000, R, 4'h0, 1'b1, 4'hC, 3'b001, 1'b0));
        tbl.push_back(mk(24'hE8004C, W, 4'h0, 1'b1, 4'h0, 3'b001, 1'b1));
        run_table("skip");

        // Shut up every board
        do_reset(3'b111);
        tbl.push_back(mk(24'hE80048, W, 4'h0, 1'b0, 4'h0, 3'b000, 1'b0));
        tbl.push_back(mk(24'hE8004C, W, 4'h0, 1'b1, 4'h0, 3'b000, 1'b0));
        tbl.push_back(mk(24'hE8004C, W, 4'h0, 1'b1, 4'h0, 3'b000, 1'b0));
        tbl.push_back(mk(24'hE8004C, W, 4'h0, 1'b1, 4'h0, 3'b000, 1'b1));
        tbl.push_back(mk(24'hE80000, R, 4'h0, 1'b0, 4'h0, 3'b000, 1'b1));
        run_table("shutup");

        // No board enabled: chain reports done at the first strobe release
        do_reset(3'b000);
        tbl.push_back(mk(24'hE80048, W, 4'h0, 1'b0, 4'h0, 3'b000, 1'b1));
        run_table("none");

        // Reset in the data phase of a base write
        do_reset(3'b111);
        tbl.push_back(mk(24'hE80048, W, 4'h0, 1'b0, 4'h0, 3'b000, 1'b0));
        tbl.push_back(mk(24'hE80000, R, 4'h0, 1'b1, 4'hE, 3'b000, 1'b0));
        tbl.push_back(mk(24'hE8004A, W, 4'h5, 1'b1, 4'h0, 3'b000, 1'b0));
        run_table("abort_pre");
        @(negedge CLK);
        ADDR = 23'h740024; RW = W; DIN = 4'h7; AS_n = 1'b0; z2_state = Z2_ADDR;
        @(negedge CLK);
        z2_state = Z2_DATA; RESET_n = 1'b0;
        @(negedge CLK);
        check("abort DOUT", 32'(DOUT), 32'h0);
        check("abort dtack", 32'(dtack), 32'h0);
        check("abort configured", 32'(configured), 32'h0);
        check("abort cfgout", 32'(cfgout), 32'h0);
        check("abort autoconfig_cycle", 32'(autoconfig_cycle), 32'h0);
        RESET_n = 1'b1; AS_n = 1'b1; z2_state = Z2_IDLE;
        @(negedge CLK);
        tbl.push_back(mk(24'hE80048, W, 4'h0, 1'b0, 4'h0, 3'b000, 1'b0));
        tbl.push_back(mk(24'hE80048, W, 4'h2, 1'b1, 4'h0, 3'b001, 1'b0)); // base 20
        run_table("abort_post");
        hits.push_back(mh(24'h200000, 3'b001));
        hits.push_back(mh(24'h250000, 3'b000));
        run_hits("abort_hit");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
